// File: rtl/vscale_dmem_ahb_bridge_if.sv
// Core data-memory port and AHB-Lite master signals for the vscale dmem bridge.
// master = bridge side, slave = core/bus environment side.
interface vscale_dmem_ahb_bridge_if;
   logic        dmem_en;
   logic        dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata_delayed;
   logic [31:0] dmem_rdata;
   logic        dmem_wait;
   logic        dmem_badmem_e;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      input  hrdata, hready, hresp,
      output dmem_rdata, dmem_wait, dmem_badmem_e,
      output haddr, hwrite, hsize, htrans, hprot, hwdata
   );

   modport slave (
      output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      output hrdata, hready, hresp,
      input  dmem_rdata, dmem_wait, dmem_badmem_e,
      input  haddr, hwrite, hsize, htrans, hprot, hwdata
   );
endinterface

// File: rtl/vscale_dmem_ahb_bridge.sv
// Bridges the vscale data port to AHB-Lite: address phase same cycle, data phase next; stalls core on hready=0.
// Optional VSCALE_DMEM_MISALIGN_CHECK_EN rejects misaligned requests locally and faults them via the MISAL state.
module vscale_dmem_ahb_bridge #(
   parameter logic [3:0] HPROT_VAL = 4'b0001
) (
   input logic                    clk,
   input logic                    reset,
   vscale_dmem_ahb_bridge_if.master bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DATA  = 2'd1;
   localparam logic [1:0] ST_ERR   = 2'd2;
`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
   localparam logic [1:0] ST_MISAL = 2'd3;
`endif

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [1:0]  launch;
   logic        wen_q;
   logic [2:0]  size_q;
   logic [1:0]  addr_q;
   logic        misal_req;
   logic        issue;
   logic        accept;
   logic        in_data;
   logic        load_done;
   logic [31:0] lane;

`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
   assign misal_req = bus.dmem_en &&
                      ((bus.dmem_size[1:0] == 2'b01 && bus.dmem_addr[0]) ||
                       (bus.dmem_size[1:0] == 2'b10 && bus.dmem_addr[1:0] != 2'b00) ||
                       (bus.dmem_size[1:0] == 2'b11));
`else
   assign misal_req = 1'b0;
`endif

   assign issue   = !reset && bus.dmem_en && (state != ST_ERR) && !misal_req;
   assign accept  = issue && bus.hready;
   assign in_data = (state == ST_DATA);

   assign bus.htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.haddr  = bus.dmem_addr;
   assign bus.hwrite = bus.dmem_wen;
   assign bus.hsize  = {1'b0, bus.dmem_size[1:0]};
   assign bus.hprot  = HPROT_VAL;

   // Where the bridge goes when the current cycle ends with no data phase holding it.
   always_comb begin
      launch = ST_IDLE;
      if (accept) begin
         launch = ST_DATA;
      end
`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
      else if (misal_req && bus.hready) begin
         launch = ST_MISAL;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_DATA: begin
            if (bus.hready) begin
               state_nxt = launch;
            end else if (bus.hresp) begin
               state_nxt = ST_ERR;
            end
         end
         ST_ERR: begin
            if (bus.hready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = launch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         wen_q  <= 1'b0;
         size_q <= 3'b000;
         addr_q <= 2'b00;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wen_q  <= bus.dmem_wen;
            size_q <= bus.dmem_size;
            addr_q <= bus.dmem_addr[1:0];
         end
      end
   end

   assign bus.dmem_wait = !reset && (state == ST_DATA || state == ST_ERR) && !bus.hready;

`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
   assign bus.dmem_badmem_e = !reset && ((state == ST_ERR && bus.hready) || state == ST_MISAL);
`else
   assign bus.dmem_badmem_e = !reset && (state == ST_ERR) && bus.hready;
`endif

   always_comb begin
      bus.hwdata = 32'h0;
      if (in_data) begin
         case (size_q[1:0])
            2'b00:   bus.hwdata = {4{bus.dmem_wdata_delayed[7:0]}};
            2'b01:   bus.hwdata = {2{bus.dmem_wdata_delayed[15:0]}};
            default: bus.hwdata = bus.dmem_wdata_delayed;
         endcase
      end
   end

   assign load_done = !reset && in_data && bus.hready && !bus.hresp && !wen_q;
   assign lane      = bus.hrdata >> {addr_q, 3'b000};

   always_comb begin
      bus.dmem_rdata = 32'h0;
      if (load_done) begin
         case (size_q)
            3'b000:  bus.dmem_rdata = {{24{lane[7]}}, lane[7:0]};
            3'b001:  bus.dmem_rdata = {{16{lane[15]}}, lane[15:0]};
            3'b100:  bus.dmem_rdata = {24'h0, lane[7:0]};
            3'b101:  bus.dmem_rdata = {16'h0, lane[15:0]};
            default: bus.dmem_rdata = bus.hrdata;
         endcase
      end
   end

endmodule

// File: doc/vscale_dmem_ahb_bridge.md
VSCALE_DMEM_AHB_BRIDGE -- requirements
Module: vscale_dmem_ahb_bridge

Interface
REQ-001 SHALL have parameter: HPROT_VAL, default 4'b0001, constant driven on hprot (data access, non-privileged).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- dmem_en  input  1  core requests access this cycle (address phase).
- dmem_wen  input  1  1 = store, 0 = load.
- dmem_size  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_addr  input  32  byte address.
- dmem_wdata_delayed  input  32  store data, valid the cycle after dmem_en.
- dmem_rdata  output  32  aligned, extended load data.
- dmem_wait  output  1  core must stall.
- dmem_badmem_e  output  1  access faulted.
- haddr  output  32  AHB address.
- hwrite  output  1  AHB write.
- hsize  output  3  AHB size.
- htrans  output  2  AHB transfer type: IDLE 00, NONSEQ 10.
- hprot  output  4  AHB protection.
- hwdata  output  32  AHB write data.
- hrdata  input  32  AHB read data.
- hready  input  1  AHB ready.
- hresp  input  1  AHB error response.
REQ-003 SHALL use reset as stated: reset reset, synchronous, active-high; clock clk.

Function
REQ-004 SHALL implement states IDLE, DATA, ERR, MISAL.
REQ-005 SHALL drive htrans=NONSEQ combinationally when dmem_en=1, state!=ERR and the request is not rejected by REQ-015; otherwise IDLE.
REQ-006 SHALL drive haddr=dmem_addr, hwrite=dmem_wen, hsize={1'b0,dmem_size[1:0]} combinationally.
REQ-007 SHALL accept an address phase when htrans=NONSEQ and hready=1, registering wen, size[2:0], addr[1:0]; next state DATA.
REQ-008 SHALL hold data-phase registers unchanged while hready=0.
REQ-009 In DATA with hready=1, hresp=0: transfer completes; next state DATA if a new address is accepted this cycle, else IDLE.
REQ-010 In DATA with hresp=1, hready=0: next state ERR; htrans forced IDLE in ERR.
REQ-011 In ERR with hready=1: dmem_badmem_e=1 for that cycle; next state IDLE.
REQ-012 SHALL drive dmem_wait=1 iff state in {DATA, ERR} and hready=0; MISAL never waits.
REQ-013 SHALL drive hwdata in the data phase from dmem_wdata_delayed with lane replication: B -> byte0 on all 4 lanes; H -> half0 on both halves; W -> unchanged.
REQ-014 SHALL drive dmem_rdata in the completing data phase by selecting the lane from the registered addr[1:0] and extending: B/H sign-extend, BU/HU zero-extend, W pass-through; dmem_rdata=0 when no load completes.

Reset
REQ-016 On reset: state IDLE, htrans IDLE, dmem_wait=0, dmem_badmem_e=0, data-phase registers 0, regardless of hready/hresp.
REQ-017 Reset mid-transfer SHALL abandon the outstanding data phase; the first post-reset cycle behaves as IDLE.

Configuration
REQ-015 With VSCALE_DMEM_MISALIGN_CHECK_EN defined: a request with H/HU and addr[0]=1, W and addr[1:0]!=0, or dmem_size[1:0]=11 SHALL drive htrans IDLE and, once hready=1, enter MISAL; MISAL asserts dmem_badmem_e=1 for one cycle, then IDLE. Without the macro: no check; all requests are issued as given and the MISAL state is absent.

Verification
REQ-018 LW addr 0x100, hrdata=0xDEADBEEF, hready=1 -> htrans=10 one cycle; next cycle dmem_rdata=0xDEADBEEF, dmem_wait=0.
REQ-019 LB addr 0x103, hrdata=0x80000000 -> dmem_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-020 SH addr 0x202, wdata_delayed=0x1234ABCD, hready low 2 cycles -> hwdata=0xABCDABCD, dmem_wait=1 for 2 cycles, then 0.
REQ-021 LW with hresp=1/hready=0 then hresp=1/hready=1 -> dmem_wait=1 one cycle, then dmem_badmem_e=1 one cycle, htrans=00 in ERR.
REQ-022 With VSCALE_DMEM_MISALIGN_CHECK_EN defined, LW addr 0x101 -> htrans=00, next cycle dmem_badmem_e=1, dmem_wait=0; back-to-back LW 0x100/0x104 -> two NONSEQ cycles in a row, no wait.
